// File: rtl/mem_share_arbiter.sv
// Front-end for a 16-entry distributed RAM: clears the RAM after every reset,
// then shares its single port between two requesters with round-robin arbitration.
module mem_share_arbiter #(
  parameter int unsigned   AW       = 4,
  parameter int unsigned   DW       = 2,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo,
  output logic          init_done
);

  localparam int unsigned    DEPTH    = 1 << AW;
  localparam int unsigned    CW       = AW + 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_init_cnt;
  logic            r_last;
  logic            r_init_done;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_init_last;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_state_nxt;
  end

  // Next state, arbitration and RAM port mux; r_last=1 means requester 1 won last.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_init_last = 1'b0;
    mem_a       = '0;
    mem_d       = '0;
    mem_we      = 1'b0;
    case (r_state)
      S_INIT: begin
        mem_a  = r_init_cnt[AW-1:0];
        mem_d  = INIT_VAL;
        mem_we = 1'b1;
        if (r_init_cnt == LAST_IDX) begin
          w_init_last = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_gnt0 = req0 & (~req1 | r_last);
        w_gnt1 = req1 & (~req0 | ~r_last);
        if (w_gnt0) begin
          mem_a  = addr0;
          mem_we = we0;
          mem_d  = wdata0;
        end else if (w_gnt1) begin
          mem_a  = addr1;
          mem_we = we1;
          mem_d  = wdata1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Clear counter is one bit wider than the address so it never wraps back into range.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + CW'(1);
      if (w_init_last)       r_init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)        r_last <= 1'b1;
    else if (w_gnt0) r_last <= 1'b0;
    else if (w_gnt1) r_last <= 1'b1;
  end

  // Read data captured from the async RAM output at the grant edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (w_gnt0 && !we0) r_rdata0 <= mem_spo;
      if (w_gnt1 && !we1) r_rdata1 <= mem_spo;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Directed bench for mem_share_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_mem_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [1:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [1:0] rdata0, rdata1;
  logic [3:0] mem_a;
  logic [1:0] mem_d;
  logic       mem_we;
  logic [1:0] mem_spo;
  logic       init_done;

  logic [1:0] ram [16];
  logic [1:0] ref_mem [16];
  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  logic [1:0] last0, last1;
  int         errors = 0;
  int         checks = 0;

  mem_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Distributed RAM: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;
  assign mem_spo = ram[mem_a];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_seq(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_init_done", init_done, 0);
    last0 = '0;
    last1 = '0;
    q0.delete();
    q1.delete();
    rst = 1'b1;
  endtask

  task automatic init_run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("init_a", mem_a, i);
      chk("init_we", mem_we, 1);
      chk("init_d", mem_d, 0);
      chk("init_gnt0", gnt0, 0);
      chk("init_gnt1", gnt1, 0);
      chk("init_done_low", init_done, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic init_finish();
    chk("init_done_high", init_done, 1);
    for (int i = 0; i < 16; i++) ref_mem[i] = 2'd0;
  endtask

  // One RUN cycle: inputs already driven; eg0/eg1 are the grants the bench expects.
  task automatic run_cycle(input bit eg0, input bit eg1);
    bit p0 = 1'b0;
    bit p1 = 1'b0;
    logic [1:0] e;
    #1;
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    if (eg0) begin
      chk("mem_a0", mem_a, addr0);
      chk("mem_we0", mem_we, we0);
      chk("mem_d0", mem_d, wdata0);
      if (!we0) begin q0.push_back(ref_mem[addr0]); p0 = 1'b1; end
      else ref_mem[addr0] = wdata0;
    end else if (eg1) begin
      chk("mem_a1", mem_a, addr1);
      chk("mem_we1", mem_we, we1);
      chk("mem_d1", mem_d, wdata1);
      if (!we1) begin q1.push_back(ref_mem[addr1]); p1 = 1'b1; end
      else ref_mem[addr1] = wdata1;
    end else begin
      chk("idle_we", mem_we, 0);
      chk("idle_a", mem_a, 0);
      chk("idle_d", mem_d, 0);
    end
    @(posedge clk);
    #1;
    chk("rvalid0", rvalid0, p0);
    chk("rvalid1", rvalid1, p1);
    if (p0) begin
      e = q0.pop_front();
      chk("rdata0", rdata0, e);
      last0 = e;
    end else chk("rdata0_hold", rdata0, last0);
    if (p1) begin
      e = q1.pop_front();
      chk("rdata1", rdata1, e);
      last1 = e;
    end else chk("rdata1_hold", rdata1, last1);
  endtask

  task automatic set0(input logic r, input logic w, input logic [3:0] a, input logic [1:0] d);
    req0 = r; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [3:0] a, input logic [1:0] d);
    req1 = r; we1 = w; addr1 = a; wdata1 = d;
  endtask

  initial begin
    rst = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 2'd0;

    // Power-up clear, then every location reads zero.
    reset_seq(2);
    init_run(16);
    init_finish();
    for (int i = 0; i < 16; i++) begin
      set0(1, 0, 4'(i), 0);
      run_cycle(1, 0);
    end
    set0(0, 0, 0, 0);
    run_cycle(0, 0);

    // Write followed immediately by read of the same address.
    set0(1, 1, 4'd5, 2'd2);
    run_cycle(1, 0);
    set0(1, 0, 4'd5, 2'd0);
    run_cycle(1, 0);
    set0(0, 0, 0, 0);
    run_cycle(0, 0);

    // Fresh init, seed a few locations, then both requesters contend.
    reset_seq(2);
    init_run(16);
    init_finish();
    set0(1, 1, 4'd1, 2'd1);  run_cycle(1, 0);
    set0(0, 0, 0, 0);
    set1(1, 1, 4'd2, 2'd3);  run_cycle(0, 1);
    set1(0, 0, 0, 0);
    set0(1, 1, 4'd4, 2'd2);  run_cycle(1, 0);
    set0(0, 0, 0, 0);
    set1(1, 1, 4'd6, 2'd1);  run_cycle(0, 1);
    set0(1, 0, 4'd1, 0); set1(1, 0, 4'd2, 0); run_cycle(1, 0);
    set0(1, 0, 4'd4, 0);                      run_cycle(0, 1);
    set1(1, 0, 4'd6, 0);                      run_cycle(1, 0);
    set0(1, 0, 4'd7, 0);                      run_cycle(0, 1);
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    run_cycle(0, 0);

    // Requester 1 waits through INIT and is granted in the first RUN cycle.
    reset_seq(2);
    set1(1, 1, 4'd3, 2'd1);
    init_run(16);
    init_finish();
    run_cycle(0, 1);
    set1(1, 0, 4'd3, 0);
    run_cycle(0, 1);
    set1(0, 0, 0, 0);
    run_cycle(0, 0);

    // Reset during INIT restarts the clear and wipes earlier writes.
    set0(1, 1, 4'd9, 2'd3);
    run_cycle(1, 0);
    set0(0, 0, 0, 0);
    reset_seq(2);
    init_run(7);
    #1;
    chk("mid_init_a", mem_a, 7);
    reset_seq(1);
    init_run(16);
    init_finish();
    set0(1, 0, 4'd9, 0);
    run_cycle(1, 0);

    // Establish nonzero read data on both ports.
    set0(1, 1, 4'd5, 2'd2);  run_cycle(1, 0);
    set0(1, 0, 4'd5, 0);     run_cycle(1, 0);
    set0(0, 0, 0, 0);
    set1(1, 1, 4'd3, 2'd1);  run_cycle(0, 1);
    set1(1, 0, 4'd3, 0);     run_cycle(0, 1);
    set1(0, 0, 0, 0);

    // Reset on the grant edge of a read suppresses its rvalid and clears read data.
    set0(1, 0, 4'd5, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_rvalid0", rvalid0, 0);
    chk("abort_rvalid1", rvalid1, 0);
    chk("abort_rdata0", rdata0, 0);
    chk("abort_rdata1", rdata1, 0);
    set0(0, 0, 0, 0);
    rst = 1'b1;
    init_run(16);
    init_finish();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
